// File: rtl/regsel_decode.sv
// Register-select decode stage.
// Captures the fetched instruction into ir and drives the register file's
// one-hot read selects (rs -> Aselect, rt -> Bselect) and the sign-extended
// immediate straight from ir. The destination register is decoded to a
// one-hot write select and carried through a WB_DEPTH-deep pipe so that
// Dselect arrives together with the write-back data.
//
// Bit 0 of every select is the "no write" / r0 encoding; the register file
// discards r0 writes, so bubbles, stores, branches and rd=0 all use 32'h1.
//
// Handshake: there is no valid/ready pair here. The destination pipe advances
// on every clock edge unconditionally; stall and flush never freeze it, they
// only inject a bubble (32'h1) at its head. wb_valid is a qualifier only: it
// is high in exactly the cycles where Dselect names a register other than r0.
//
// WB_DEPTH: edges from instruction capture to Dselect, legal range 1..8.

module regsel_decode #(
    parameter int WB_DEPTH = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ibus,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] Aselect,
    output logic [31:0] Bselect,
    output logic [31:0] Dselect,
    output logic [31:0] imm,
    output logic        wb_valid
);

    localparam logic [31:0] SEL_NONE = 32'h0000_0001;

    // ID instruction register and destination pipe; r_dpipe[0] is the
    // youngest stage, r_dpipe[WB_DEPTH-1] feeds the register file.
    logic [31:0] r_ir;
    logic [31:0] r_dpipe [WB_DEPTH];

    logic [5:0]  w_opcode;
    logic [31:0] w_dest;
    logic        w_bubble;

    assign w_opcode = r_ir[31:26];
    assign w_bubble = stall | flush;

    // Instruction register: reset, then flush (NOP), then stall (hold), else load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir <= 32'h0;
        end else if (flush) begin
            r_ir <= 32'h0;
        end else if (!stall) begin
            r_ir <= ibus;
        end
    end

    // Destination decode: R-type writes rd, branches and stores write nothing,
    // every other opcode is an I-type that writes rt.
    always_comb begin
        w_dest = SEL_NONE << r_ir[20:16];
        casez (w_opcode)
            6'b000000: w_dest = SEL_NONE << r_ir[15:11];
            6'b000100,
            6'b000101: w_dest = SEL_NONE;
            6'b101???: w_dest = SEL_NONE;
            default:   w_dest = SEL_NONE << r_ir[20:16];
        endcase
    end

    // Destination pipe: always shifts; a stalled or flushed ID slot enters as a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < WB_DEPTH; k++) begin
                r_dpipe[k] <= SEL_NONE;
            end
        end else begin
            r_dpipe[0] <= w_bubble ? SEL_NONE : w_dest;
            for (int k = 1; k < WB_DEPTH; k++) begin
                r_dpipe[k] <= r_dpipe[k-1];
            end
        end
    end

    assign Aselect  = SEL_NONE << r_ir[25:21];
    assign Bselect  = SEL_NONE << r_ir[20:16];
    assign imm      = {{16{r_ir[15]}}, r_ir[15:0]};
    assign Dselect  = r_dpipe[WB_DEPTH-1];
    assign wb_valid = ~Dselect[0];

endmodule

// File: tb/tb_regsel_decode.sv
// Testbench for regsel_decode (WB_DEPTH = 3).
// The driver applies directed instructions with hand-decoded selects and
// pushes the expected per-cycle outputs into queues; an independent monitor
// pops one entry per cycle and compares against the DUT.

module tb_regsel_decode;

    localparam int WB_DEPTH = 3;

    logic        clk;
    logic        reset;
    logic [31:0] ibus;
    logic        stall;
    logic        flush;
    logic [31:0] Aselect;
    logic [31:0] Bselect;
    logic [31:0] Dselect;
    logic [31:0] imm;
    logic        wb_valid;

    regsel_decode #(.WB_DEPTH(WB_DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .ibus     (ibus),
        .stall    (stall),
        .flush    (flush),
        .Aselect  (Aselect),
        .Bselect  (Bselect),
        .Dselect  (Dselect),
        .imm      (imm),
        .wb_valid (wb_valid)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_d_q  [$];  // expected Dselect, one entry per cycle
    logic [95:0] exp_ab_q [$];  // expected {Aselect, Bselect, imm}, one per cycle
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          check_en = 1'b0;

    // Model of what ir currently holds, as hand-decoded values.
    logic [31:0] m_a, m_b, m_imm, m_dest;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (check_en) begin
            if (exp_d_q.size() == 0 || exp_ab_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_underflow: queue empty at t=%0t", $time);
            end else begin
                logic [31:0] ed;
                logic [95:0] eab;
                ed  = exp_d_q.pop_front();
                eab = exp_ab_q.pop_front();
                check("Dselect",  Dselect, ed);
                check("wb_valid", {31'b0, wb_valid}, {31'b0, ~ed[0]});
                check("Aselect",  Aselect, eab[95:64]);
                check("Bselect",  Bselect, eab[63:32]);
                check("imm",      imm,     eab[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_reset_model();
        m_a = 32'h1; m_b = 32'h1; m_imm = 32'h0; m_dest = 32'h1;
        exp_d_q.delete();
        exp_ab_q.delete();
        for (int i = 0; i < WB_DEPTH; i++) exp_d_q.push_back(32'h1);
        exp_ab_q.push_back({m_a, m_b, m_imm});
    endtask

    // Assert reset for one edge (stall/flush may be held high to show override).
    task automatic apply_reset(input logic st, input logic fl);
        reset = 1'b1;
        stall = st;
        flush = fl;
        ibus  = 32'h00A41820;
        @(posedge clk); #1;
        load_reset_model();
        check_en = 1'b1;
    endtask

    // One clock of stimulus. a/b/im/d are the hand-decoded selects of instr.
    task automatic drive(input logic [31:0] instr, input logic st, input logic fl,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] d);
        reset = 1'b0;
        ibus  = instr;
        stall = st;
        flush = fl;
        @(posedge clk); #1;
        exp_d_q.push_back((st || fl) ? 32'h1 : m_dest);
        if (fl) begin
            m_a = 32'h1; m_b = 32'h1; m_imm = 32'h0; m_dest = 32'h1;
        end else if (!st) begin
            m_a = a; m_b = b; m_imm = im; m_dest = d;
        end
        exp_ab_q.push_back({m_a, m_b, m_imm});
    endtask

    task automatic nop();
        drive(32'h0, 1'b0, 1'b0, 32'h1, 32'h1, 32'h0, 32'h1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        ibus  = 32'h0;
        stall = 1'b0;
        flush = 1'b0;
        @(posedge clk); #1;
        apply_reset(1'b0, 1'b0);

        // Back-to-back mix: R-type, I-type neg imm, store, branch, rt=0,
        // load, bne, all-31 R-type, sb, ori with negative immediate.
        drive(32'h00A41820, 0, 0, 32'h00000020, 32'h00000010, 32'h00001820, 32'h00000008);
        drive(32'h2046FFFF, 0, 0, 32'h00000004, 32'h00000040, 32'hFFFFFFFF, 32'h00000040);
        drive(32'hAC450004, 0, 0, 32'h00000004, 32'h00000020, 32'h00000004, 32'h00000001);
        drive(32'h10450002, 0, 0, 32'h00000004, 32'h00000020, 32'h00000002, 32'h00000001);
        drive(32'h20200005, 0, 0, 32'h00000002, 32'h00000001, 32'h00000005, 32'h00000001);
        drive(32'h8C8A0010, 0, 0, 32'h00000010, 32'h00000400, 32'h00000010, 32'h00000400);
        drive(32'h14A60003, 0, 0, 32'h00000020, 32'h00000040, 32'h00000003, 32'h00000001);
        drive(32'h03FFF820, 0, 0, 32'h80000000, 32'h80000000, 32'hFFFFF820, 32'h80000000);
        drive(32'hA0C70008, 0, 0, 32'h00000040, 32'h00000080, 32'h00000008, 32'h00000001);
        drive(32'h34E88000, 0, 0, 32'h00000080, 32'h00000100, 32'hFFFF8000, 32'h00000100);

        // Stall two cycles on an rd=7 R-type: ir holds, two bubbles precede 0x80.
        drive(32'h00223820, 0, 0, 32'h00000002, 32'h00000004, 32'h00003820, 32'h00000080);
        drive(32'h00854820, 1, 0, 32'h00000010, 32'h00000020, 32'h00004820, 32'h00000200);
        drive(32'h00854820, 1, 0, 32'h00000010, 32'h00000020, 32'h00004820, 32'h00000200);
        // rd=9 instruction now captured, then flushed with stall also high.
        drive(32'h00854820, 0, 0, 32'h00000010, 32'h00000020, 32'h00004820, 32'h00000200);
        drive(32'h00A41820, 1, 1, 32'h00000020, 32'h00000010, 32'h00001820, 32'h00000008);
        drive(32'h2046FFFF, 0, 0, 32'h00000004, 32'h00000040, 32'hFFFFFFFF, 32'h00000040);

        // Fill the pipe with real writes, then reset with stall held high.
        drive(32'h00A41820, 0, 0, 32'h00000020, 32'h00000010, 32'h00001820, 32'h00000008);
        drive(32'h03FFF820, 0, 0, 32'h80000000, 32'h80000000, 32'hFFFFF820, 32'h80000000);
        drive(32'h8C8A0010, 0, 0, 32'h00000010, 32'h00000400, 32'h00000010, 32'h00000400);
        apply_reset(1'b1, 1'b0);

        // Recovery after reset.
        nop();
        drive(32'h00223820, 0, 0, 32'h00000002, 32'h00000004, 32'h00003820, 32'h00000080);
        for (int i = 0; i < WB_DEPTH + 1; i++) nop();

        @(negedge clk); #1;
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
